// File: rtl/calc_operand_sequencer_if.sv
// Switch, button, add/sub unit and result signals of the calculator front end.
// res_valid is a level: high while res_sign/res_mag hold a computed result; there is no ready back-pressure.
interface calc_operand_sequencer_if;
  logic [2:0] sw_val;
  logic       sw_op;
  logic       btn_enter;
  logic       btn_clear;
  logic       as_operation;
  logic [2:0] as_a;
  logic [2:0] as_b;
  logic [4:0] as_c;
  logic       res_sign;
  logic [2:0] res_mag;
  logic       res_valid;
  logic [2:0] state_o;

  modport master (
    input  sw_val, sw_op, btn_enter, btn_clear, as_c,
    output as_operation, as_a, as_b, res_sign, res_mag, res_valid, state_o
  );

  modport slave (
    output sw_val, sw_op, btn_enter, btn_clear, as_c,
    input  as_operation, as_a, as_b, res_sign, res_mag, res_valid, state_o
  );
endinterface

// File: rtl/calc_operand_sequencer.sv
// Debounces enter/clear, sequences operand A, operation and operand B into the
// add/sub unit, then captures its result into a held display register.
module calc_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  calc_operand_sequencer_if.master  bus
);

  localparam logic [7:0] LP_DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  // Index 0 = enter, 1 = clear.
  logic [1:0] w_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_stable;
  logic [1:0] r_stable_q;
  logic [7:0] r_cnt [2];
  logic       w_enter_evt;
  logic       w_clear_evt;

  assign w_raw = {bus.btn_clear, bus.btn_enter};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1    <= 2'b00;
      r_sync2    <= 2'b00;
      r_stable   <= 2'b00;
      r_stable_q <= 2'b00;
      for (int i = 0; i < 2; i++) r_cnt[i] <= 8'd0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= 8'd0;
        end else if (r_cnt[i] == LP_DB_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= 8'd0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign w_enter_evt = r_stable[0] & ~r_stable_q[0];
  assign w_clear_evt = r_stable[1] & ~r_stable_q[1];

  // The downstream converter mis-encodes -0, so it is folded to +0 here.
  function automatic logic [2:0] normalise(input logic [2:0] v);
    return (v[1:0] == 2'b00) ? 3'b000 : v;
  endfunction

  state_t     r_state, w_state_nxt;
  logic       r_as_op, w_as_op_nxt;
  logic [2:0] r_as_a, w_as_a_nxt;
  logic [2:0] r_as_b, w_as_b_nxt;
  logic       r_res_sign, w_res_sign_nxt;
  logic [2:0] r_res_mag, w_res_mag_nxt;
  logic       r_res_valid, w_res_valid_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_A;
      r_as_op     <= 1'b0;
      r_as_a      <= 3'b000;
      r_as_b      <= 3'b000;
      r_res_sign  <= 1'b0;
      r_res_mag   <= 3'b000;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_as_op     <= w_as_op_nxt;
      r_as_a      <= w_as_a_nxt;
      r_as_b      <= w_as_b_nxt;
      r_res_sign  <= w_res_sign_nxt;
      r_res_mag   <= w_res_mag_nxt;
      r_res_valid <= w_res_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_as_op_nxt     = r_as_op;
    w_as_a_nxt      = r_as_a;
    w_as_b_nxt      = r_as_b;
    w_res_sign_nxt  = r_res_sign;
    w_res_mag_nxt   = r_res_mag;
    w_res_valid_nxt = r_res_valid;
    if (w_clear_evt) begin
      w_state_nxt     = S_A;
      w_as_op_nxt     = 1'b0;
      w_as_a_nxt      = 3'b000;
      w_as_b_nxt      = 3'b000;
      w_res_sign_nxt  = 1'b0;
      w_res_mag_nxt   = 3'b000;
      w_res_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_A: if (w_enter_evt) begin
          w_as_a_nxt  = normalise(bus.sw_val);
          w_state_nxt = S_OP;
        end
        S_OP: if (w_enter_evt) begin
          w_as_op_nxt = bus.sw_op;
          w_state_nxt = S_B;
        end
        S_B: if (w_enter_evt) begin
          w_as_b_nxt  = normalise(bus.sw_val);
          w_state_nxt = S_EXEC;
        end
        // as_c has settled from the operand registers by now; bit 3 is unused.
        S_EXEC: begin
          w_res_mag_nxt   = bus.as_c[2:0];
          w_res_sign_nxt  = bus.as_c[4] & (bus.as_c[2:0] != 3'b000);
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = S_SHOW;
        end
        S_SHOW: if (w_enter_evt) begin
          w_as_a_nxt      = normalise(bus.sw_val);
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = S_OP;
        end
        default: w_state_nxt = S_A;
      endcase
    end
  end

  assign bus.as_operation = r_as_op;
  assign bus.as_a         = r_as_a;
  assign bus.as_b         = r_as_b;
  assign bus.res_sign     = r_res_sign;
  assign bus.res_mag      = r_res_mag;
  assign bus.res_valid    = r_res_valid;
  assign bus.state_o      = r_state;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer with a behavioural sign-magnitude add/sub unit.
module tb_calc_operand_sequencer;

  localparam int DB   = 4;
  localparam int HOLD = 14;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  calc_operand_sequencer_if bus ();

  calc_operand_sequencer #(.DEBOUNCE_CYCLES(DB)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational add/sub unit: signed integer arithmetic on sign-magnitude operands.
  int m_a, m_b, m_r;
  always_comb begin
    m_a = bus.as_a[2] ? -int'(bus.as_a[1:0]) : int'(bus.as_a[1:0]);
    m_b = bus.as_b[2] ? -int'(bus.as_b[1:0]) : int'(bus.as_b[1:0]);
    m_r = bus.as_operation ? (m_a - m_b) : (m_a + m_b);
    bus.as_c = {(m_r < 0), 1'b0, 3'((m_r < 0) ? -m_r : m_r)};
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic press_enter(input logic [2:0] val, input logic op);
    bus.sw_val    = val;
    bus.sw_op     = op;
    bus.btn_enter = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1 bus.btn_enter = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      if (bus.state_o == exp) hit = 1'b1;
    end
    chk(tag, 8'(hit), 8'd1);
  endtask

  // Enter in S_B, then check the one-cycle EXEC latency and the captured result.
  task automatic run_b(input string tag, input logic [2:0] val, input logic [2:0] exp_b,
                       input logic exp_sign, input logic [2:0] exp_mag);
    bus.sw_val    = val;
    bus.btn_enter = 1'b1;
    wait_state({tag, "_exec_reach"}, 3'd3, 30);
    chk({tag, "_exec_valid"}, 8'(bus.res_valid), 8'd0);
    chk({tag, "_as_b"}, 8'(bus.as_b), 8'(exp_b));
    @(negedge clk);
    chk({tag, "_show"}, 8'(bus.state_o), 8'd4);
    chk({tag, "_valid"}, 8'(bus.res_valid), 8'd1);
    chk({tag, "_sign"}, 8'(bus.res_sign), 8'(exp_sign));
    chk({tag, "_mag"}, 8'(bus.res_mag), 8'(exp_mag));
    @(posedge clk);
    #1 bus.btn_enter = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 8'(bus.state_o), 8'd0);
    chk({tag, "_as_a"}, 8'(bus.as_a), 8'd0);
    chk({tag, "_as_b"}, 8'(bus.as_b), 8'd0);
    chk({tag, "_op"}, 8'(bus.as_operation), 8'd0);
    chk({tag, "_sign"}, 8'(bus.res_sign), 8'd0);
    chk({tag, "_mag"}, 8'(bus.res_mag), 8'd0);
    chk({tag, "_valid"}, 8'(bus.res_valid), 8'd0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.sw_val    = 3'b000;
    bus.sw_op     = 1'b0;
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 2 - (-3) = +5
    press_enter(3'b010, 1'b0);
    @(negedge clk);
    chk("s1_as_a", 8'(bus.as_a), 8'h2);
    chk("s1_state_op", 8'(bus.state_o), 8'd1);
    press_enter(3'b000, 1'b1);
    @(negedge clk);
    chk("s1_as_op", 8'(bus.as_operation), 8'd1);
    chk("s1_state_b", 8'(bus.state_o), 8'd2);
    run_b("s1", 3'b111, 3'b111, 1'b0, 3'd5);

    // -0 + -1 = -1, A normalised to +0; old result stays held meanwhile
    press_enter(3'b100, 1'b0);
    @(negedge clk);
    chk("s2_as_a_norm", 8'(bus.as_a), 8'h0);
    chk("s2_state_op", 8'(bus.state_o), 8'd1);
    chk("s2_valid_drop", 8'(bus.res_valid), 8'd0);
    chk("s2_mag_held", 8'(bus.res_mag), 8'd5);
    press_enter(3'b000, 1'b0);
    run_b("s2", 3'b101, 3'b101, 1'b1, 3'd1);

    // 1 - 1 = 0
    press_enter(3'b001, 1'b0);
    press_enter(3'b000, 1'b1);
    run_b("s3", 3'b001, 3'b001, 1'b0, 3'd0);

    // 3 + -2 = +1
    press_enter(3'b011, 1'b0);
    press_enter(3'b000, 1'b0);
    run_b("s4", 3'b110, 3'b110, 1'b0, 3'd1);

    // Short glitch below the debounce threshold
    bus.sw_val    = 3'b011;
    bus.btn_enter = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.btn_enter = 1'b0;
    repeat (HOLD) @(posedge clk);
    @(negedge clk);
    chk("glitch_state", 8'(bus.state_o), 8'd4);
    chk("glitch_valid", 8'(bus.res_valid), 8'd1);

    // Long hold gives exactly one event
    @(posedge clk);
    #1 bus.btn_enter = 1'b1;
    repeat (50) @(posedge clk);
    #1 bus.btn_enter = 1'b0;
    repeat (HOLD) @(posedge clk);
    @(negedge clk);
    chk("hold_state", 8'(bus.state_o), 8'd1);
    chk("hold_as_a", 8'(bus.as_a), 8'h3);
    chk("hold_mag_held", 8'(bus.res_mag), 8'd1);

    // Clear and enter together in S_B: clear wins
    @(posedge clk);
    #1;
    press_enter(3'b000, 1'b1);
    @(negedge clk);
    chk("both_pre_state", 8'(bus.state_o), 8'd2);
    @(posedge clk);
    #1;
    bus.btn_enter = 1'b1;
    bus.btn_clear = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1;
    bus.btn_enter = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (HOLD) @(posedge clk);
    @(negedge clk);
    chk_all_zero("both");

    // 1 + 2 = +3, then a one-cycle reset while showing it
    @(posedge clk);
    #1;
    press_enter(3'b001, 1'b0);
    press_enter(3'b000, 1'b0);
    run_b("s5", 3'b010, 3'b010, 1'b0, 3'd3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
